// File: rtl/sp1_ope_arb_pkg.sv
// -----------------------------------------------------------------------------
// sp1_ope_arb_pkg
//   Shared constants for the operator arbiter: opcode encodings of the shared
//   operator datapath and the arbiter FSM state type.
// -----------------------------------------------------------------------------
package sp1_ope_arb_pkg;

    localparam logic [2:0] SP1_OP_ADD  = 3'd0;
    localparam logic [2:0] SP1_OP_INCR = 3'd1;
    localparam logic [2:0] SP1_OP_DECR = 3'd2;
    localparam logic [2:0] SP1_OP_EQ   = 3'd3;
    localparam logic [2:0] SP1_OP_GT   = 3'd4;

    typedef enum logic [1:0] {
        SP1_ARB_IDLE = 2'd0,
        SP1_ARB_EXEC = 2'd1,
        SP1_ARB_RESP = 2'd2
    } sp1_arb_state_e;

endpackage

// File: rtl/sp1_rr_arb.sv
// -----------------------------------------------------------------------------
// sp1_rr_arb
//   Combinational round-robin pick: the first asserted request found searching
//   upward from ptr_i, wrapping NREQ-1 -> 0.
// Ports:
//   req_i      request vector
//   ptr_i      highest-priority index for this pick
//   gnt_o      one-hot grant (all zero when no request)
//   gnt_idx_o  encoded grant index (0 when no request)
//   any_o      at least one request asserted
// -----------------------------------------------------------------------------
module sp1_rr_arb #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o,
    output logic            any_o
);

    logic [IW-1:0] idx;

    // NREQ is a power of two, so an IW-bit add wraps exactly at NREQ.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr_i + IW'(k);
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_idx_o  = idx;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sp1_ope_arb.sv
// -----------------------------------------------------------------------------
// sp1_ope_arb
//   Round-robin arbiter/sequencer sharing one operator datapath (add, incr,
//   decr, eq, gt) among NREQ requesters. One operation in flight at a time:
//   IDLE grants and captures, EXEC evaluates and registers the result, RESP
//   holds the tagged result until the consumer accepts it.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_op/req_a/req_b    per-requester opcode and operands, flat-packed
//   rsp_valid/rsp_ready   result handshake
//   rsp_id                requester index owning the result
//   rsp_y/rsp_flag        result value and carry/borrow/eq/gt flag
//   rsp_err               illegal opcode
// -----------------------------------------------------------------------------
module sp1_ope_arb
    import sp1_ope_arb_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*3-1:0]    req_op,
    input  logic [NREQ*DW-1:0]   req_a,
    input  logic [NREQ*DW-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IW-1:0]        rsp_id,
    output logic [DW-1:0]        rsp_y,
    output logic                 rsp_flag,
    output logic                 rsp_err
);

    sp1_arb_state_e state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [2:0]     op_q;
    logic [DW-1:0]  a_q, b_q;
    logic [IW-1:0]  id_q;
    logic [IW-1:0]  rsp_id_q;
    logic [DW-1:0]  rsp_y_q;
    logic           rsp_flag_q, rsp_err_q;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            cap_en, res_en;

    sp1_rr_arb #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (gnt_any)
    );

    // ---------------------------------------------------------------------
    // Shared operator datapath on the captured operands
    // ---------------------------------------------------------------------
    logic [DW:0]   add_sum, inc_sum, dec_dif;
    logic          cmp_eq, cmp_gt;
    logic [DW-1:0] res_y;
    logic          res_flag, res_err;

    always_comb begin
        add_sum = {1'b0, a_q} + {1'b0, b_q};
        inc_sum = {1'b0, a_q} + (DW+1)'(1);
        // Top bit of the widened difference is the borrow (set only for a=0).
        dec_dif = {1'b0, a_q} - (DW+1)'(1);
        cmp_eq  = (a_q == b_q);
        cmp_gt  = (a_q >  b_q);
    end

    always_comb begin
        res_y    = '0;
        res_flag = 1'b0;
        res_err  = 1'b0;
        case (op_q)
            SP1_OP_ADD:  begin res_y = add_sum[DW-1:0]; res_flag = add_sum[DW]; end
            SP1_OP_INCR: begin res_y = inc_sum[DW-1:0]; res_flag = inc_sum[DW]; end
            SP1_OP_DECR: begin res_y = dec_dif[DW-1:0]; res_flag = dec_dif[DW]; end
            SP1_OP_EQ:   res_flag = cmp_eq;
            SP1_OP_GT:   res_flag = cmp_gt;
            default:     res_err  = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------------
    // Sequencing FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cap_en  = 1'b0;
        res_en  = 1'b0;
        case (state_q)
            SP1_ARB_IDLE: begin
                if (gnt_any) begin
                    cap_en  = 1'b1;
                    ptr_d   = gnt_idx + IW'(1);
                    state_d = SP1_ARB_EXEC;
                end
            end
            SP1_ARB_EXEC: begin
                res_en  = 1'b1;
                state_d = SP1_ARB_RESP;
            end
            SP1_ARB_RESP: begin
                if (rsp_ready) state_d = SP1_ARB_IDLE;
            end
            default: state_d = SP1_ARB_IDLE;
        endcase
    end

    // Grant is only offered while idle; the FSM owns the single op slot.
    assign req_ready = (state_q == SP1_ARB_IDLE) ? gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SP1_ARB_IDLE;
            ptr_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            rsp_id_q   <= '0;
            rsp_y_q    <= '0;
            rsp_flag_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (cap_en) begin
                op_q <= req_op[3*int'(gnt_idx) +: 3];
                a_q  <= req_a[DW*int'(gnt_idx) +: DW];
                b_q  <= req_b[DW*int'(gnt_idx) +: DW];
                id_q <= gnt_idx;
            end
            if (res_en) begin
                rsp_id_q   <= id_q;
                rsp_y_q    <= res_y;
                rsp_flag_q <= res_flag;
                rsp_err_q  <= res_err;
            end
        end
    end

    assign rsp_valid = (state_q == SP1_ARB_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_flag  = rsp_flag_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sp1_ope_arb.sv
// -----------------------------------------------------------------------------
// tb_sp1_ope_arb
//   Directed scenarios plus a randomized run checked against a transaction-
//   level model (round-robin pick, arithmetic result, in-order response).
// -----------------------------------------------------------------------------
module tb_sp1_ope_arb;

    localparam int DW = 8;
    localparam int NREQ = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      req_valid = '0;
    logic [3:0]      req_ready;
    logic [11:0]     req_op = '0;
    logic [31:0]     req_a = '0;
    logic [31:0]     req_b = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [1:0]      rsp_id;
    logic [7:0]      rsp_y;
    logic            rsp_flag;
    logic            rsp_err;

    int n_chk = 0;
    int n_fail = 0;

    sp1_ope_arb #(.DW(DW), .NREQ(NREQ), .IW(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_flag(rsp_flag), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Reference: result of one operation from the opcode rules, plain integers.
    function automatic void ref_op(input int op, input int a, input int b,
                                   output int y, output int fl, output int er);
        int s;
        y = 0; fl = 0; er = 0;
        case (op)
            0: begin s = a + b; y = s % 256; fl = (s > 255); end
            1: begin s = a + 1; y = s % 256; fl = (s > 255); end
            2: begin y = (a + 255) % 256; fl = (a == 0); end
            3: fl = (a == b);
            4: fl = (a > b);
            default: er = 1;
        endcase
    endfunction

    function automatic int pick();
        case ($urandom_range(0, 3))
            0: return 0;
            1: return 255;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic set_req(input int i, input int op, input int a, input int b);
        req_op[3*i +: 3] = 3'(op);
        req_a[8*i +: 8]  = 8'(a);
        req_b[8*i +: 8]  = 8'(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one request and returns the observed response (ok=0 on timeout).
    task automatic run_one(input int idx, input int op, input int a, input int b,
                           output int y, output int fl, output int er, output int id,
                           output bit ok);
        y = -1; fl = -1; er = -1; id = -1; ok = 0;
        rsp_ready = 1'b1;
        @(negedge clk);
        set_req(idx, op, a, b);
        req_valid = 4'b0001 << idx;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (req_ready[idx]) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin req_valid = '0; return; end
        @(negedge clk);
        req_valid = '0;
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (rsp_valid) begin
                ok = 1; y = int'(rsp_y); fl = int'(rsp_flag); er = int'(rsp_err); id = int'(rsp_id);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit seen;
        do_reset();
        #1;
        n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_chk++; if ({rsp_id, rsp_y, rsp_flag, rsp_err} !== 12'h000)
            begin n_fail++; $display("FAIL reset_rsp_fields id=%0d y=%h flag=%b err=%b exp all 0", rsp_id, rsp_y, rsp_flag, rsp_err); end
        // Reset while an op from requester 1 is in EXEC.
        @(negedge clk);
        set_req(1, 0, 8'h11, 8'h22);
        req_valid = 4'b0010;
        #1;
        n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rst_exec_grant got=%b exp=0010", req_ready); end
        @(negedge clk);
        req_valid = '0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin #1; if (rsp_valid) seen = 1; @(negedge clk); end
        n_chk++; if (seen) begin n_fail++; $display("FAIL rst_exec_no_rsp got rsp_valid=1 exp never"); end
        // ptr back at 0: all requesting -> requester 0 wins.
        req_valid = 4'b1111;
        #1;
        n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_exec_ptr got=%b exp=0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 0, 8'hF0, 8'h20);
        req_valid = 4'b0001; rsp_ready = 1'b1;
        #1;
        n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_chk++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0)
            begin n_fail++; $display("FAIL single_exec ready=%b rsp_valid=%b exp 0000/0", req_ready, rsp_valid); end
        @(negedge clk);
        #1;
        n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_y !== 8'h10 || rsp_flag !== 1'b1 || rsp_err !== 1'b0)
            begin n_fail++; $display("FAIL single_rsp v=%b id=%0d y=%h f=%b e=%b exp 1/0/10/1/0", rsp_valid, rsp_id, rsp_y, rsp_flag, rsp_err); end
        @(negedge clk);
        #1;
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_drop got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        int gi[$], gc[$];
        int idx;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 0, pick(), pick());
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (req_ready != 4'b0000) begin
                idx = -1;
                for (int j = 0; j < 4; j++) if (req_ready[j]) idx = j;
                gi.push_back(idx); gc.push_back(c);
            end
            @(negedge clk);
        end
        req_valid = '0;
        n_chk++;
        if (gi.size() < 5) begin n_fail++; $display("FAIL rr_count got=%0d grants exp>=5", gi.size()); end
        else begin
            for (int k = 0; k < 5; k++) begin
                n_chk++;
                if (gi[k] != k % 4 || gc[k] != 3 * k)
                    begin n_fail++; $display("FAIL rr_grant%0d idx=%0d cyc=%0d exp idx=%0d cyc=%0d", k, gi[k], gc[k], k % 4, 3 * k); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit bad;
        do_reset();
        set_req(1, 2, 8'h00, 8'h00);
        set_req(2, 0, 8'h01, 8'h02);
        req_valid = 4'b0110; rsp_ready = 1'b0;
        #1;
        n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant got=%b exp=0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b0100;
        @(negedge clk);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (rsp_valid !== 1'b1 || rsp_y !== 8'hFF || rsp_flag !== 1'b1 || rsp_id !== 2'd1 || req_ready !== 4'b0000) begin
                bad = 1;
                $display("FAIL bp_hold cyc=%0d v=%b y=%h f=%b id=%0d rdy=%b exp 1/ff/1/1/0000", c, rsp_valid, rsp_y, rsp_flag, rsp_id, req_ready);
            end
            @(negedge clk);
        end
        n_chk++; if (bad) n_fail++;
        rsp_ready = 1'b1;
        #1;
        n_chk++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0000)
            begin n_fail++; $display("FAIL bp_accept_cycle v=%b rdy=%b exp 1/0000", rsp_valid, req_ready); end
        @(negedge clk);
        #1;
        n_chk++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0100)
            begin n_fail++; $display("FAIL bp_release v=%b rdy=%b exp 0/0100", rsp_valid, req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_y !== 8'h03 || rsp_flag !== 1'b0)
            begin n_fail++; $display("FAIL bp_second v=%b id=%0d y=%h f=%b exp 1/2/03/0", rsp_valid, rsp_id, rsp_y, rsp_flag); end
        @(negedge clk);
    endtask

    task automatic test_compare();
        int y, fl, er, id;
        bit ok;
        do_reset();
        run_one(0, 3, 8'h5A, 8'h5A, y, fl, er, id, ok);
        n_chk++; if (!ok || y != 0 || fl != 1 || er != 0)
            begin n_fail++; $display("FAIL cmp_eq ok=%0d y=%0d f=%0d e=%0d exp 1/0/1/0", ok, y, fl, er); end
        run_one(0, 4, 8'h80, 8'h7F, y, fl, er, id, ok);
        n_chk++; if (!ok || y != 0 || fl != 1 || er != 0)
            begin n_fail++; $display("FAIL cmp_gt_true ok=%0d y=%0d f=%0d e=%0d exp 1/0/1/0", ok, y, fl, er); end
        run_one(0, 4, 8'h7F, 8'h80, y, fl, er, id, ok);
        n_chk++; if (!ok || y != 0 || fl != 0 || er != 0)
            begin n_fail++; $display("FAIL cmp_gt_false ok=%0d y=%0d f=%0d e=%0d exp 1/0/0/0", ok, y, fl, er); end
        run_one(0, 3, 8'h5A, 8'h5B, y, fl, er, id, ok);
        n_chk++; if (!ok || y != 0 || fl != 0 || er != 0)
            begin n_fail++; $display("FAIL cmp_eq_false ok=%0d y=%0d f=%0d e=%0d exp 1/0/0/0", ok, y, fl, er); end
    endtask

    task automatic test_illegal();
        int y, fl, er, id;
        bit ok;
        do_reset();
        run_one(3, 6, 8'hA5, 8'h3C, y, fl, er, id, ok);
        n_chk++; if (!ok || er != 1 || y != 0 || fl != 0 || id != 3)
            begin n_fail++; $display("FAIL illegal_op ok=%0d e=%0d y=%0d f=%0d id=%0d exp 1/1/0/0/3", ok, er, y, fl, id); end
        run_one(3, 1, 8'hFF, 8'h00, y, fl, er, id, ok);
        n_chk++; if (!ok || er != 0 || y != 0 || fl != 1 || id != 3)
            begin n_fail++; $display("FAIL illegal_then_legal ok=%0d e=%0d y=%0d f=%0d id=%0d exp 1/0/0/1/3", ok, er, y, fl, id); end
    endtask

    task automatic test_random();
        int ptr, acc_prev, g, wait_cnt, ey, ef, ee;
        int q_id[$], q_y[$], q_f[$], q_e[$];
        int r_op[4], r_a[4], r_b[4];
        logic [3:0] exp_rdy;
        bit qe;
        do_reset();
        ptr = 0; acc_prev = -1; wait_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            if (acc_prev >= 0) req_valid[acc_prev] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    r_op[i] = int'($urandom_range(0, 7)); r_a[i] = pick(); r_b[i] = pick();
                    set_req(i, r_op[i], r_a[i], r_b[i]);
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            qe = (q_y.size() == 0);
            if (rsp_valid) begin
                n_chk++;
                if (qe) begin n_fail++; $display("FAIL rnd_rsp_spurious cyc=%0d id=%0d y=%h", c, rsp_id, rsp_y); end
                else begin
                    if (int'(rsp_id) != q_id[0] || int'(rsp_y) != q_y[0] || int'(rsp_flag) != q_f[0] || int'(rsp_err) != q_e[0]) begin
                        n_fail++;
                        $display("FAIL rnd_rsp cyc=%0d id=%0d y=%h f=%b e=%b exp id=%0d y=%h f=%0d e=%0d",
                                 c, rsp_id, rsp_y, rsp_flag, rsp_err, q_id[0], q_y[0], q_f[0], q_e[0]);
                    end
                    if (rsp_ready) begin
                        void'(q_id.pop_front()); void'(q_y.pop_front());
                        void'(q_f.pop_front()); void'(q_e.pop_front());
                    end
                end
                wait_cnt = 0;
            end else if (!qe) begin
                wait_cnt++;
                if (wait_cnt > 1) begin
                    n_chk++; n_fail++;
                    $display("FAIL rnd_rsp_late cyc=%0d rsp_valid=0 exp 1", c);
                    wait_cnt = 0;
                end
            end
            exp_rdy = '0; g = -1;
            if (qe && req_valid != 4'b0000) begin
                for (int k = 0; k < 4; k++)
                    if (g < 0 && req_valid[(ptr + k) % 4]) g = (ptr + k) % 4;
                exp_rdy[g] = 1'b1;
            end
            n_chk++;
            if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
            acc_prev = -1;
            if (g >= 0 && req_ready === exp_rdy) begin
                ref_op(r_op[g], r_a[g], r_b[g], ey, ef, ee);
                q_id.push_back(g); q_y.push_back(ey); q_f.push_back(ef); q_e.push_back(ee);
                ptr = (g + 1) % 4;
                acc_prev = g;
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_compare();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sp1_ope_arb.md
Name: sp1_ope_arb

Overview:
Round-robin arbiter and sequencer that shares one operator datapath (sp1_adder, sp1_incr, sp1_decr, sp1_comp_eq, sp1_comp_gt) among NREQ requesters in the STG machine core.
- Grants one request at a time, captures its operands, drives the shared operators and returns a registered result tagged with the requester index.
- Sits between the evaluator's micro-op issue units and the shared operator instances.

Parameters:
DW, 32, operand/result width in bits
NREQ, 4, number of requesters; power of two, at least 2
IW, 2, requester index width; equals log2(NREQ)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept; at most one bit high
req_op  input  NREQ*3  per-requester opcode; slice i = [3*i+2:3*i]
req_a  input  NREQ*DW  per-requester operand A; slice i = [DW*i+DW-1:DW*i]
req_b  input  NREQ*DW  per-requester operand B; same slicing as req_a
rsp_valid  output  1  result valid
rsp_ready  input  1  result consumer accept
rsp_id  output  IW  index of the requester owning the result
rsp_y  output  DW  result value
rsp_flag  output  1  carry, borrow, eq or gt flag, per opcode
rsp_err  output  1  illegal opcode

Behaviour:
- Reset state: state=IDLE, ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_flag=0, rsp_err=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Granted index g = first i with req_valid[i], searching from ptr upward with wrap NREQ-1 -> 0.
  - req_ready[g]=1, combinational from req_valid and ptr; all other bits 0.
  - If any req_valid: capture op/a/b/g into internal registers, set ptr=(g+1) mod NREQ, go to EXEC.
  - If no req_valid: stay in IDLE; ptr unchanged.
- req_ready is 0 in EXEC and RESP. Requesters hold valid/op/a/b stable until they see ready.
- EXEC (one cycle): the shared operators act on the captured operands; register the result, then go to RESP.
  - op 0 ADD: y=a+b, flag=carry out.
  - op 1 INCR: y=a+1, flag=carry.
  - op 2 DECR: y=a-1, flag=borrow.
  - op 3 EQ: y=0, flag=(a==b).
  - op 4 GT: y=0, flag=(a>b), unsigned.
  - op 5-7: y=0, flag=0, err=1.
  - All arithmetic is modulo 2^DW.
- RESP:
  - rsp_valid=1; rsp_id/y/flag/err hold stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid=0 at the next edge, go to IDLE.
  - rsp_ready high on the first RESP cycle means RESP lasts exactly one cycle.
- Latency: accept edge N, result registered at N+1, rsp_valid visible in cycle N+1 to N+2.
  - Minimum issue interval is 3 cycles: IDLE, EXEC, RESP.
- Fairness: a continuously asserted requester is granted within NREQ grants.
- rst asserted in any state: next edge returns to the reset state. The in-flight op is discarded and no response is issued.
- Requests arriving in EXEC or RESP wait. There is no queueing beyond the requester's own hold.

Decomposition:
- sp1_common.h carries the following:
  - Opcode constants: SP1_OP_ADD=3'd0, SP1_OP_INCR=3'd1, SP1_OP_DECR=3'd2, SP1_OP_EQ=3'd3, SP1_OP_GT=3'd4.
  - State encodings: SP1_ARB_IDLE, SP1_ARB_EXEC, SP1_ARB_RESP.
- One sub-module, sp1_rr_arb (NREQ, IW): inputs are the request vector and ptr; outputs are the one-hot grant, the encoded index and any-valid.
- The operator instances are reused unchanged inside sp1_ope_arb.

Test Plan:
All scenarios use DW=8, NREQ=4.
1. Reset mid-EXEC: rst high during EXEC, released -> state IDLE, rsp_valid never rises, ptr=0.
2. Single request: req_valid=0001, op=ADD, a=8'hF0, b=8'h20 -> req_ready=0001 one cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_y=8'h10, rsp_flag=1.
3. Round-robin: req_valid=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; each grant 3 cycles apart.
4. Backpressure: op=DECR, a=8'h00, rsp_ready=0 for 5 cycles -> rsp_valid stays high with rsp_y=8'hFF, rsp_flag=1 stable; req_ready stays 0 for requester 2 waiting; released one cycle after rsp_ready.
5. Compare ops: EQ a=b=8'h5A -> flag=1, y=0; GT a=8'h80, b=8'h7F -> flag=1; GT a=8'h7F, b=8'h80 -> flag=0.
6. Illegal op=3'd6 from requester 3 -> rsp_err=1, rsp_y=0, rsp_flag=0, rsp_id=3; next op legal -> rsp_err=0.
